// File: rtl/inst_fetch_stage_pkg.sv
// Shared definitions for the instruction fetch stage: FSM encoding and fixed constants.
package inst_fetch_stage_pkg;

  typedef enum logic [1:0] {
    StReq      = 2'd0,
    StWaitData = 2'd1,
    StHold     = 2'd2,
    StDiscard  = 2'd3
  } fetch_state_e;

  localparam logic [31:0] ResetPcDefault = 32'hBFC00000;
  localparam logic [31:0] NopInstr       = 32'h0000_0000;
  localparam logic [1:0]  InstSizeWord   = 2'b10;

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry {instr, pc} holding buffer used while decode is stalled.
// clear wins over load, load wins over unload.
module fetch_skid_buf (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        load_i,
  input  logic        unload_i,
  input  logic        clear_i,
  input  logic [31:0] instr_i,
  input  logic [31:0] pc_i,
  output logic        valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o
);

  logic        valid_q, valid_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_q, pc_d;

  // Next-state for occupancy and payload
  always_comb begin
    valid_d = valid_q;
    instr_d = instr_q;
    pc_d    = pc_q;
    if (clear_i) begin
      valid_d = 1'b0;
    end else if (load_i) begin
      valid_d = 1'b1;
      instr_d = instr_i;
      pc_d    = pc_i;
    end else if (unload_i) begin
      valid_d = 1'b0;
    end
  end

  // Buffer registers, synchronous active-low reset
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      instr_q <= '0;
      pc_q    <= '0;
    end else begin
      valid_q <= valid_d;
      instr_q <= instr_d;
      pc_q    <= pc_d;
    end
  end

  assign valid_o = valid_q;
  assign instr_o = instr_q;
  assign pc_o    = pc_q;

endmodule

// File: rtl/inst_fetch_stage.sv
// Instruction fetch stage: owns the PC, drives the sram-like instruction port and the
// instrD/pcD decode register. Delayed-branch redirect and flush redirect are handled here.
// Optional build macro FETCH_PERF_CNT_EN adds fetch_cnt and fetch_stall_cnt outputs.
module inst_fetch_stage
  import inst_fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = ResetPcDefault
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        stallD,
  input  logic        flush,
  input  logic [31:0] newpc,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        inst_req,
  output logic        inst_wr,
  output logic [1:0]  inst_size,
  output logic [31:0] inst_addr,
  output logic [31:0] inst_wdata,
  input  logic        inst_addr_ok,
  input  logic        inst_data_ok,
  input  logic [31:0] inst_rdata,
  output logic [31:0] instrD,
  output logic [31:0] pcD,
  output logic        validD,
  output logic        adelD
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] fetch_cnt,
  output logic [31:0] fetch_stall_cnt
`endif
);

  fetch_state_e state_q, state_d;

  logic [31:0] pc_q, pc_d;
  logic [31:0] instrd_q, instrd_d;
  logic [31:0] pcd_q, pcd_d;
  logic        validd_q, validd_d;
  logic        adeld_q, adeld_d;
  logic        redirect_pending_q, redirect_pending_d;
  logic [31:0] redirect_target_q, redirect_target_d;

  logic        misaligned;
  logic        req_issue;
  logic        redir_pend;
  logic [31:0] redir_tgt;
  logic [31:0] next_pc;
  logic        deliver_mem;
  logic        buffer_mem;
  logic        unload;
  logic        deliver_adel;
  logic        advance;

  logic        skid_valid;
  logic [31:0] skid_instr;
  logic [31:0] skid_pc;

  assign misaligned = (pc_q[1:0] != 2'b00);
  assign req_issue  = (state_q == StReq) && !misaligned;

  // A branch resolving in the same cycle the delay slot is consumed redirects immediately.
  assign redir_pend = redirect_pending_q | branch_taken;
  assign redir_tgt  = branch_taken ? branch_target : redirect_target_q;
  assign next_pc    = redir_pend ? redir_tgt : pc_q + 32'd4;

  assign deliver_mem  = (state_q == StWaitData) && inst_data_ok && !stallD;
  assign buffer_mem   = (state_q == StWaitData) && inst_data_ok && stallD;
  assign unload       = (state_q == StHold) && !stallD && skid_valid;
  assign deliver_adel = (state_q == StReq) && misaligned && !stallD;
  assign advance      = deliver_mem | unload;

  // FSM state register
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= StReq;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state; a flush with a response still owed must swallow that response
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StReq: begin
        if (flush) begin
          state_d = (req_issue && inst_addr_ok) ? StDiscard : StReq;
        end else if (req_issue && inst_addr_ok) begin
          state_d = StWaitData;
        end
      end
      StWaitData: begin
        if (flush) begin
          state_d = inst_data_ok ? StReq : StDiscard;
        end else if (inst_data_ok) begin
          state_d = stallD ? StHold : StReq;
        end
      end
      StHold: begin
        if (flush || !stallD) begin
          state_d = StReq;
        end
      end
      StDiscard: begin
        if (inst_data_ok) begin
          state_d = StReq;
        end
      end
    endcase
  end

  // FSM outputs: request port
  always_comb begin
    inst_req   = resetn && req_issue;
    inst_addr  = pc_q;
    inst_wr    = 1'b0;
    inst_size  = InstSizeWord;
    inst_wdata = '0;
  end

  // Datapath next-state: PC, decode register, pending redirect
  always_comb begin
    pc_d               = pc_q;
    instrd_d           = instrd_q;
    pcd_d              = pcd_q;
    validd_d           = validd_q;
    adeld_d            = adeld_q;
    redirect_pending_d = redirect_pending_q;
    redirect_target_d  = redirect_target_q;

    if (branch_taken) begin
      redirect_pending_d = 1'b1;
      redirect_target_d  = branch_target;
    end

    if (flush) begin
      pc_d               = newpc;
      instrd_d           = NopInstr;
      validd_d           = 1'b0;
      adeld_d            = 1'b0;
      redirect_pending_d = 1'b0;
    end else begin
      if (advance) begin
        pc_d               = next_pc;
        redirect_pending_d = 1'b0;
      end
      if (deliver_mem) begin
        instrd_d = inst_rdata;
        pcd_d    = pc_q;
        validd_d = 1'b1;
        adeld_d  = 1'b0;
      end else if (unload) begin
        instrd_d = skid_instr;
        pcd_d    = skid_pc;
        validd_d = 1'b1;
        adeld_d  = 1'b0;
      end else if (deliver_adel) begin
        instrd_d = NopInstr;
        pcd_d    = pc_q;
        validd_d = 1'b1;
        adeld_d  = 1'b1;
      end else if (!stallD) begin
        // Decode consumed the previous entry and nothing new arrived: insert a bubble
        instrd_d = NopInstr;
        validd_d = 1'b0;
        adeld_d  = 1'b0;
      end
    end
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (!resetn) begin
      pc_q               <= RESET_PC;
      instrd_q           <= NopInstr;
      pcd_q              <= '0;
      validd_q           <= 1'b0;
      adeld_q            <= 1'b0;
      redirect_pending_q <= 1'b0;
      redirect_target_q  <= '0;
    end else begin
      pc_q               <= pc_d;
      instrd_q           <= instrd_d;
      pcd_q              <= pcd_d;
      validd_q           <= validd_d;
      adeld_q            <= adeld_d;
      redirect_pending_q <= redirect_pending_d;
      redirect_target_q  <= redirect_target_d;
    end
  end

  fetch_skid_buf u_skid (
    .clk_i    (clk),
    .rst_ni   (resetn),
    .load_i   (buffer_mem && !flush),
    .unload_i (unload && !flush),
    .clear_i  (flush),
    .instr_i  (inst_rdata),
    .pc_i     (pc_q),
    .valid_o  (skid_valid),
    .instr_o  (skid_instr),
    .pc_o     (skid_pc)
  );

  assign instrD = instrd_q;
  assign pcD    = pcd_q;
  assign validD = validd_q;
  assign adelD  = adeld_q;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] fetch_stall_cnt_q, fetch_stall_cnt_d;
  logic        count_evt;

  // A held AdEL entry is re-presented every cycle but counts only once
  assign count_evt = !flush && (advance || (deliver_adel && !(validd_q && adeld_q)));

  // Performance counter next-state (wrapping)
  always_comb begin
    fetch_cnt_d       = fetch_cnt_q + {31'd0, count_evt};
    fetch_stall_cnt_d = fetch_stall_cnt_q + {31'd0, (state_q == StHold)};
  end

  // Performance counter registers
  always_ff @(posedge clk) begin
    if (!resetn) begin
      fetch_cnt_q       <= '0;
      fetch_stall_cnt_q <= '0;
    end else begin
      fetch_cnt_q       <= fetch_cnt_d;
      fetch_stall_cnt_q <= fetch_stall_cnt_d;
    end
  end

  assign fetch_cnt       = fetch_cnt_q;
  assign fetch_stall_cnt = fetch_stall_cnt_q;
`endif

endmodule

// File: tb/tb_inst_fetch_stage.sv
// Randomized bench for inst_fetch_stage: a bench-side memory answers the sram-like port and
// an instruction-stream scoreboard predicts the next PC decode must see.
module tb_inst_fetch_stage;

  localparam logic [31:0] RstPc = 32'hBFC00000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        resetn, stallD, flush, branch_taken;
  logic [31:0] newpc, branch_target;
  logic        inst_req, inst_wr;
  logic [1:0]  inst_size;
  logic [31:0] inst_addr, inst_wdata;
  logic        inst_addr_ok, inst_data_ok;
  logic [31:0] inst_rdata;
  logic [31:0] instrD, pcD;
  logic        validD, adelD;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt, fetch_stall_cnt;
`endif

  inst_fetch_stage #(.RESET_PC(RstPc)) dut (
    .clk           (clk),
    .resetn        (resetn),
    .stallD        (stallD),
    .flush         (flush),
    .newpc         (newpc),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .inst_req      (inst_req),
    .inst_wr       (inst_wr),
    .inst_size     (inst_size),
    .inst_addr     (inst_addr),
    .inst_wdata    (inst_wdata),
    .inst_addr_ok  (inst_addr_ok),
    .inst_data_ok  (inst_data_ok),
    .inst_rdata    (inst_rdata),
    .instrD        (instrD),
    .pcD           (pcD),
    .validD        (validD),
    .adelD         (adelD)
`ifdef FETCH_PERF_CNT_EN
    ,
    .fetch_cnt       (fetch_cnt),
    .fetch_stall_cnt (fetch_stall_cnt)
`endif
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5A5A_0F0F;
  endfunction

  // Reference model: next instruction address decode must receive, plus pending redirect
  logic [31:0] exp_pc, pend_tgt;
  logic        pend;
  // Bench memory: at most one outstanding read
  logic        mem_busy;
  logic [31:0] mem_addr;
  int          mem_lat;
  int          deliveries, adel_seen;
  // Inputs/outputs of the cycle just clocked
  logic        p_resetn, p_stall, p_flush, p_branch, p_req, p_addr_ok, p_data_ok, p_clean;
  logic [31:0] p_newpc, p_target, p_addr;
  // Decode register as sampled one cycle earlier
  logic        last_valid, last_adel;
  logic [31:0] last_instr, last_pcd;
  logic        rst_done, fresh_after_rst;

  task automatic model_reset();
    exp_pc   = RstPc;
    pend     = 1'b0;
    pend_tgt = '0;
    mem_busy = 1'b0;
    mem_lat  = 0;
  endtask

  task automatic sample_last();
    last_valid = validD;
    last_adel  = adelD;
    last_instr = instrD;
    last_pcd   = pcD;
  endtask

  task automatic update();
    logic advanced;
    advanced = 1'b0;
    if (!p_resetn) begin
      check("rst_valid", 32'(validD), 32'd0);
      check("rst_req", 32'(inst_req), 32'd0);
      check("rst_pcd", pcD, 32'd0);
      model_reset();
    end else begin
      // memory side
      if (p_data_ok) begin
        mem_busy = 1'b0;
      end else if (mem_busy) begin
        mem_lat--;
      end
      if (p_req && p_addr_ok) begin
        check("one_outstanding", 32'(mem_busy), 32'd0);
        check("req_addr", p_addr, exp_pc);
        mem_busy = 1'b1;
        mem_addr = p_addr;
        mem_lat  = p_clean ? 0 : int'($urandom_range(0, 2));
      end
      if (p_req && !p_addr_ok && !p_flush) begin
        check("req_held", 32'(inst_req), 32'd1);
        check("addr_stable", inst_addr, p_addr);
      end
      // decode side
      if (p_flush) begin
        check("flush_valid", 32'(validD), 32'd0);
        check("flush_adel", 32'(adelD), 32'd0);
        exp_pc = p_newpc;
        pend   = 1'b0;
      end else if (p_stall) begin
        check("hold_valid", 32'(validD), 32'(last_valid));
        check("hold_instr", instrD, last_instr);
        check("hold_pcd", pcD, last_pcd);
        check("hold_adel", 32'(adelD), 32'(last_adel));
      end else if (validD) begin
        deliveries++;
        check("pcd", pcD, exp_pc);
        if (exp_pc[1:0] != 2'b00) begin
          adel_seen++;
          check("adel_flag", 32'(adelD), 32'd1);
          check("adel_instr", instrD, 32'd0);
        end else begin
          check("adel_clear", 32'(adelD), 32'd0);
          check("instr", instrD, mem_word(exp_pc));
          if (p_branch)  exp_pc = p_target;
          else if (pend) exp_pc = pend_tgt;
          else           exp_pc = exp_pc + 32'd4;
          pend     = 1'b0;
          advanced = 1'b1;
        end
      end
      if (!p_flush && p_branch && !advanced) begin
        pend     = 1'b1;
        pend_tgt = p_target;
      end
      if (exp_pc[1:0] != 2'b00) check("misaligned_no_req", 32'(inst_req), 32'd0);
    end
    sample_last();
  endtask

  initial begin
    resetn = 1'b0; stallD = 1'b0; flush = 1'b0; newpc = '0;
    branch_taken = 1'b0; branch_target = '0;
    inst_addr_ok = 1'b0; inst_data_ok = 1'b0; inst_rdata = '0;
    deliveries = 0; adel_seen = 0; rst_done = 1'b0; fresh_after_rst = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_req", 32'(inst_req), 32'd0);
    check("reset_valid", 32'(validD), 32'd0);
    check("reset_instr", instrD, 32'd0);
    check("reset_pcd", pcD, 32'd0);
    check("reset_adel", 32'(adelD), 32'd0);
    check("inst_wr", 32'(inst_wr), 32'd0);
    check("inst_size", 32'(inst_size), 32'd2);
    check("inst_wdata", inst_wdata, 32'd0);
    sample_last();
    resetn = 1'b1;
    #1;
    check("first_req", 32'(inst_req), 32'd1);
    check("first_addr", inst_addr, RstPc);

    for (int cyc = 0; cyc < 4000; cyc++) begin
      p_clean = (cyc < 20);
      if (!rst_done && cyc >= 2000 && mem_busy && exp_pc[1:0] == 2'b00) begin
        // reset while a read is outstanding
        rst_done = 1'b1;
        resetn = 1'b0; stallD = 1'b0; flush = 1'b0; branch_taken = 1'b0;
        inst_addr_ok = 1'b0; inst_data_ok = 1'b0;
        fresh_after_rst = 1'b1;
      end else begin
        resetn = 1'b1;
        #1;
        if (fresh_after_rst) begin
          check("req_after_rst", 32'(inst_req), 32'd1);
          check("addr_after_rst", inst_addr, RstPc);
          fresh_after_rst = 1'b0;
        end
        stallD       = !p_clean && ($urandom_range(0, 99) < 30);
        flush        = !p_clean && ($urandom_range(0, 99) < 3);
        case ($urandom_range(0, 5))
          0:       newpc = 32'hBFC00380;
          1:       newpc = 32'h80000002;
          default: newpc = $urandom & 32'hFFFF_FFFC;
        endcase
        branch_taken = !p_clean && ($urandom_range(0, 99) < 5);
        case ($urandom_range(0, 3))
          0:       branch_target = 32'h80001000;
          1:       branch_target = 32'hFFFFFFFC;
          default: branch_target = $urandom & 32'hFFFF_FFFC;
        endcase
        inst_addr_ok = inst_req && (p_clean || ($urandom_range(0, 99) < 70));
        if (mem_busy && mem_lat == 0) begin
          inst_data_ok = 1'b1;
          inst_rdata   = mem_word(mem_addr);
        end else begin
          inst_data_ok = 1'b0;
          inst_rdata   = $urandom;
        end
      end
      #1;
      p_resetn  = resetn;    p_stall   = stallD;       p_flush   = flush;
      p_newpc   = newpc;     p_branch  = branch_taken; p_target  = branch_target;
      p_req     = inst_req;  p_addr    = inst_addr;
      p_addr_ok = inst_addr_ok; p_data_ok = inst_data_ok;
      @(posedge clk);
      @(negedge clk);
      update();
    end

    check("enough_deliveries", 32'(deliveries > 200), 32'd1);
    check("adel_exercised", 32'(adel_seen > 0), 32'd1);
    check("mid_reset_done", 32'(rst_done), 32'd1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/inst_fetch_stage.md
Name: inst_fetch_stage

Overview:
- Fetch stage feeding the decode stage of the 5-stage MIPS core.
- Holds the PC and drives the sram-like instruction port (req/addr_ok/data_ok).
- Applies the branch/jump redirect after the delay slot and exception redirects.
- Registers instrD/pcD consumed by the main decoder.

Parameters:
RESET_PC, 32'hBFC00000, PC loaded on reset.

Ports:
clk  in  1  core clock.
resetn  in  1  reset; synchronous, active-low.
stallD  in  1  decode stage stalled; hold instrD/pcD/validD.
flush  in  1  exception/eret flush; one-cycle pulse.
newpc  in  32  redirect PC accompanying flush.
branch_taken  in  1  branch/jump resolved taken in D; one-cycle pulse.
branch_target  in  32  target accompanying branch_taken.
inst_req  out  1  instruction request.
inst_wr  out  1  constant 0.
inst_size  out  2  constant 2'b10.
inst_addr  out  32  request address (= pc).
inst_wdata  out  32  constant 0.
inst_addr_ok  in  1  address accepted.
inst_data_ok  in  1  read data valid.
inst_rdata  in  32  read data.
instrD  out  32  instruction to decode.
pcD  out  32  PC of instrD.
validD  out  1  instrD is a real fetched instruction.
adelD  out  1  instrD comes from a misaligned PC (AdEL).

Behaviour:
- Reset (resetn=0 at posedge):
  - pc=RESET_PC, state=REQ.
  - instrD=0 (NOP), pcD=0, validD=0, adelD=0.
  - redirect_pending=0, skid buffer empty. inst_req=0 while resetn=0.
- States: REQ, WAIT_DATA, HOLD, DISCARD.
- REQ:
  - inst_req=1, inst_addr=pc.
  - inst_req is held until inst_addr_ok; address is stable while waiting.
  - On addr_ok go to WAIT_DATA.
  - If pc[1:0]!=0: no request issued. Deliver instrD=0, adelD=1, validD=1 (same stall rules), then stay in REQ with pc unchanged until flush.
- WAIT_DATA, on data_ok:
  - If !stallD: instrD<=inst_rdata, pcD<=pc, validD<=1, adelD<=0; pc<=next_pc; go to REQ.
  - If stallD: rdata goes into the 1-entry skid buffer; go to HOLD.
- HOLD:
  - No request.
  - When stallD falls: buffer moves to instrD/pcD, pc<=next_pc, state REQ. inst_req is asserted that same cycle with the new pc.
- next_pc:
  - redirect_pending ? redirect_target : pc+4. Consuming it clears redirect_pending.
- branch_taken latches redirect_pending=1 and redirect_target, so the instruction in flight (the delay slot) is delivered first.
- branch_taken with stallD=1: still latched exactly once; a repeated pulse overwrites the target.
- flush has priority over everything:
  - pc<=newpc; validD<=0, instrD<=0, adelD<=0.
  - redirect_pending<=0, skid buffer emptied.
  - If a request is accepted but data is not yet returned (WAIT_DATA, or REQ with addr_ok in the same cycle): go to DISCARD. DISCARD drops the next data_ok, then goes to REQ.
  - Otherwise go to REQ; inst_req is asserted with newpc the next cycle.
  - Flush while in DISCARD: update pc only; keep discarding the single outstanding response.
- While stallD=1: instrD/pcD/validD/adelD hold. Fetch may continue until the skid buffer is full; at most one outstanding request.
- PC arithmetic is 32-bit modulo; 32'hFFFFFFFC+4 wraps to 0.
- Latency: data_ok in cycle N gives instrD valid in N+1. Back-to-back throughput with a 1-cycle memory is one instruction per 2 cycles.

Optional Feature:
- Macro FETCH_PERF_CNT_EN.
- Defined: adds output fetch_cnt (32), counting delivered valid instructions (flush-discarded ones excluded). Adds output fetch_stall_cnt (32), counting cycles in HOLD. Both reset to 0 and wrap.
- Undefined: neither port nor counter exists; behaviour otherwise identical.

Decomposition:
- Shared package/header:
  - FSM state encodings (REQ=2'd0, WAIT_DATA=2'd1, HOLD=2'd2, DISCARD=2'd3).
  - RESET_PC default.
  - NOP_INSTR=32'h0.
  - inst_size word constant.
- Sub-module fetch_skid_buf: 1-entry {instr, pc} buffer with load/unload/clear.

Test Plan:
- Reset then 1-cycle-latency memory returning pc as data → first req addr 32'hBFC00000; instrD/pcD sequence BFC00000, BFC00004, BFC00008 with validD=1.
- stallD=1 for 3 cycles while data_ok arrives → instrD holds its old value; buffered instr appears the cycle after stallD falls; no instruction lost or duplicated.
- branch_taken target 32'h80001000 while the delay slot at BFC00010 is in flight → pcD sequence BFC00010, 80001000.
- flush newpc=32'hBFC00380 in WAIT_DATA, then data_ok with 32'hDEADBEEF → DEADBEEF never reaches instrD; validD=0; next req addr BFC00380.
- flush newpc=32'h80000002 → no inst_req; validD=1, adelD=1, pcD=80000002, instrD=0.
- resetn=0 mid-WAIT_DATA → next cycle pc=BFC00000, validD=0, inst_req=0; req reasserts after resetn=1.
